edc_corrector: RTL and testbench
================================

Name: edc_corrector

Overview:
- Read-side counterpart of the (40,32) IBM-8130-style ECC generator.
- Takes a 32-bit data word and its stored 8-bit check code from memory. Computes the syndrome and corrects any single-bit error. Flags double and other uncorrectable errors.
- Two-stage pipeline with valid/ready handshakes on both sides, saturating error counters, and first-error address capture. Sits between the memory array read port and the cache/bus read-return path.

Parameters:
- AW, 32, width of the address/tag carried alongside each word.
- CNT_W, 16, width of the saturating error counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset (asynchronous, active-high)
- i_valid  in  1  upstream word valid
- o_ready  out  1  upstream may present a word
- i_addr  in  AW  address of the word (passthrough and logging)
- i_data  in  32  raw data from memory
- i_ecc  in  8  stored check code from memory
- o_valid  out  1  corrected word valid
- i_ready  in  1  downstream accepts the word
- o_addr  out  AW  address aligned with o_data
- o_data  out  32  corrected data
- o_ce  out  1  correctable error on this word (data or check bit)
- o_ue  out  1  uncorrectable error on this word
- o_syndrome  out  8  syndrome of this word
- i_cnt_clr  in  1  synchronous clear of counters and capture registers
- o_ce_cnt  out  CNT_W  saturating correctable-error count
- o_ue_cnt  out  CNT_W  saturating uncorrectable-error count
- o_err_addr  out  AW  address of the first error since the last clear
- o_err_vld  out  1  o_err_addr holds a valid capture

Behaviour:
- Parity-check rows over data bits [31:0]; ecc[r] pairs with row r:
  - r0 0xAAAAC0C0, r1 0x55553030, r2 0xFF000C0C, r3 0x00FF0303
  - r4 0xC0C0FF00, r5 0x303000FF, r6 0x0C0CAAAA, r7 0x03035555
- Syndrome: s[r] = (^(row_r & i_data)) ^ i_ecc[r].
- Every data column has odd weight (3). Decode rules:
  - s==0: no error.
  - s equals the column of data bit j: flip bit j, o_ce=1.
  - s has weight 1: check-bit error, data unchanged, o_ce=1.
  - Any other s (even weight, or odd weight not matching a column): o_ue=1, data passed through uncorrected.
- Stage 1 registers data, addr and syndrome. Stage 2 registers corrected data and flags.
- Latency is 2 cycles from accept (i_valid&&o_ready) to o_valid.
- Handshake:
  - o_ready = !s2_valid || i_ready; the pipeline advances as a unit.
  - Words are never dropped or duplicated.
  - While o_valid && !i_ready, o_data, o_addr and the flags are held stable.
- Counters:
  - o_ce_cnt increments by 1 on each word that leaves stage 2 (o_valid&&i_ready) with o_ce. o_ue_cnt does the same for o_ue.
  - Both counters saturate at all-ones.
- Capture: on the first such flagged handoff while !o_err_vld, load o_err_addr and set o_err_vld. Later errors do not overwrite it.
- i_cnt_clr has priority over a same-cycle increment or capture: counters go to 0 and o_err_vld goes to 0.
- Reset values: o_valid=0, o_ready=1, o_data=0, o_addr=0, o_ce=0, o_ue=0, o_syndrome=0, o_ce_cnt=0, o_ue_cnt=0, o_err_addr=0, o_err_vld=0.
- Reset mid-operation discards all in-flight words.

Optional Feature:
- Macro: EDC_SCRUB_EN.
- With the macro defined, add these ports:
  - o_scrub_req out 1
  - o_scrub_addr out AW
  - o_scrub_data out 32
  - o_scrub_ecc out 8
  - i_scrub_ack in 1
- Scrub request behaviour:
  - On a correctable-error handoff, raise o_scrub_req with the address, corrected data and freshly generated ecc.
  - The request is held until i_scrub_ack and then drops the next cycle.
  - While a request is pending, stage 2 will not hand off another CE word: o_valid is held low for it and back-pressure applies.
  - Reset value of o_scrub_req is 0.
- Without the macro, these ports and this logic are absent.

Test Plan:
- data 0x00000000, ecc 0x00 -> 2 cycles later o_data=0x00000000, o_ce=0, o_ue=0, o_syndrome=0x00.
- data 0x00000001, ecc 0x00 -> o_syndrome=0xA8, o_data=0x00000000, o_ce=1, o_ce_cnt=1, o_err_addr=the word's addr.
- data 0x00000000, ecc 0x01 -> o_syndrome=0x01, o_data=0x00000000, o_ce=1.
- data 0x00000003, ecc 0x00 -> o_syndrome=0xC0, o_ue=1, o_data=0x00000003, o_ue_cnt=1.
- Stream of 8 words with i_ready low for 3 cycles mid-stream -> outputs stable while stalled, all 8 words delivered in order, o_ready low only while s2 is full and stalled.
- i_cnt_clr asserted in the same cycle as a CE handoff -> o_ce_cnt=0, o_err_vld=0. With CNT_W=2 and 5 CE words -> o_ce_cnt=3.

Source files
------------

// File: rtl/edc_corrector.sv
// Read-side (40,32) SEC/DED corrector with a two-stage valid/ready pipeline,
// saturating error counters and first-error address capture. Optional scrub port: EDC_SCRUB_EN.
module edc_corrector #(
   parameter int AW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [AW-1:0]    i_addr,
   input  logic [31:0]      i_data,
   input  logic [7:0]       i_ecc,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [AW-1:0]    o_addr,
   output logic [31:0]      o_data,
   output logic             o_ce,
   output logic             o_ue,
   output logic [7:0]       o_syndrome,
`ifdef EDC_SCRUB_EN
   output logic             o_scrub_req,
   output logic [AW-1:0]    o_scrub_addr,
   output logic [31:0]      o_scrub_data,
   output logic [7:0]       o_scrub_ecc,
   input  logic             i_scrub_ack,
`endif
   input  logic             i_cnt_clr,
   output logic [CNT_W-1:0] o_ce_cnt,
   output logic [CNT_W-1:0] o_ue_cnt,
   output logic [AW-1:0]    o_err_addr,
   output logic             o_err_vld
);

   localparam logic [7:0][31:0] ROWS = {
      32'h03035555, 32'h0C0CAAAA, 32'h303000FF, 32'hC0C0FF00,
      32'h00FF0303, 32'hFF000C0C, 32'h55553030, 32'hAAAAC0C0
   };

   function automatic logic [7:0] gen_check(input logic [31:0] d);
      logic [7:0] c;
      for (int r = 0; r < 8; r++) c[r] = ^(ROWS[r] & d);
      return c;
   endfunction

   function automatic logic [7:0] column(input int j);
      logic [7:0] c;
      for (int r = 0; r < 8; r++) c[r] = ROWS[r][j];
      return c;
   endfunction

   logic            s1_valid;
   logic [AW-1:0]   s1_addr;
   logic [31:0]     s1_data;
   logic [7:0]      s1_syn;

   logic            s2_valid;
   logic [AW-1:0]   s2_addr;
   logic [31:0]     s2_data;
   logic [7:0]      s2_syn;
   logic            s2_ce;
   logic            s2_ue;

   logic [31:0]     dec_data;
   logic            dec_ce;
   logic            dec_ue;
   logic            hit;
   logic            out_valid;
   logic            handoff;
   logic            advance;

   // A weight-1 syndrome is a check-bit error; any other nonzero value must hit a data column.
   always_comb begin
      dec_data = s1_data;
      dec_ce   = 1'b0;
      dec_ue   = 1'b0;
      hit      = 1'b0;
      if (s1_syn != 8'h00) begin
         if ($onehot(s1_syn)) begin
            dec_ce = 1'b1;
         end else begin
            for (int j = 0; j < 32; j++) begin
               if (s1_syn == column(j)) begin
                  dec_data[j] = ~s1_data[j];
                  hit         = 1'b1;
               end
            end
            dec_ce = hit;
            dec_ue = ~hit;
         end
      end
   end

`ifdef EDC_SCRUB_EN
   logic scrub_pend;
   // A CE word waiting behind an unacknowledged scrub is hidden from the consumer.
   assign out_valid = s2_valid && !(scrub_pend && s2_ce);
`else
   assign out_valid = s2_valid;
`endif

   assign handoff = out_valid && i_ready;
   assign advance = !s2_valid || handoff;
   assign o_ready = advance;

   assign o_valid    = out_valid;
   assign o_addr     = s2_addr;
   assign o_data     = s2_data;
   assign o_ce       = s2_ce;
   assign o_ue       = s2_ue;
   assign o_syndrome = s2_syn;

   // Both stages move together whenever stage 2 is empty or handing off.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         s2_data  <= '0;
         s2_syn   <= '0;
         s2_ce    <= 1'b0;
         s2_ue    <= 1'b0;
      end else if (advance) begin
         s1_valid <= i_valid;
         s1_addr  <= i_addr;
         s1_data  <= i_data;
         s1_syn   <= gen_check(i_data) ^ i_ecc;
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         s2_data  <= dec_data;
         s2_syn   <= s1_syn;
         s2_ce    <= s1_valid & dec_ce;
         s2_ue    <= s1_valid & dec_ue;
      end
   end

   // Clear wins over a same-cycle increment or capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ce_cnt   <= '0;
         o_ue_cnt   <= '0;
         o_err_addr <= '0;
         o_err_vld  <= 1'b0;
      end else if (i_cnt_clr) begin
         o_ce_cnt   <= '0;
         o_ue_cnt   <= '0;
         o_err_vld  <= 1'b0;
      end else if (handoff) begin
         if (s2_ce && (o_ce_cnt != '1)) o_ce_cnt <= o_ce_cnt + CNT_W'(1);
         if (s2_ue && (o_ue_cnt != '1)) o_ue_cnt <= o_ue_cnt + CNT_W'(1);
         if ((s2_ce || s2_ue) && !o_err_vld) begin
            o_err_addr <= s2_addr;
            o_err_vld  <= 1'b1;
         end
      end
   end

`ifdef EDC_SCRUB_EN
   // Write-back request for a corrected word, held until acknowledged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scrub_pend   <= 1'b0;
         o_scrub_addr <= '0;
         o_scrub_data <= '0;
         o_scrub_ecc  <= '0;
      end else if (scrub_pend) begin
         if (i_scrub_ack) scrub_pend <= 1'b0;
      end else if (handoff && s2_ce) begin
         scrub_pend   <= 1'b1;
         o_scrub_addr <= s2_addr;
         o_scrub_data <= s2_data;
         o_scrub_ecc  <= gen_check(s2_data);
      end
   end

   assign o_scrub_req = scrub_pend;
`endif

endmodule

// File: tb/tb_edc_corrector.sv
// Directed bench for edc_corrector: decode vectors, stalled stream, counter clear,
// saturation (second instance with CNT_W=2) and mid-flight reset.
module tb_edc_corrector;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [7:0]  in_ecc;
   logic        cnt_clr;

   logic        out_ready, out_valid, out_ce, out_ue, err_vld;
   logic [31:0] out_addr, out_data, err_addr;
   logic [7:0]  out_syn;
   logic [15:0] ce_cnt, ue_cnt;

   logic        d2_ready, d2_valid, d2_ce, d2_ue, d2_err_vld;
   logic [31:0] d2_addr, d2_data, d2_err_addr;
   logic [7:0]  d2_syn;
   logic [1:0]  d2_ce_cnt, d2_ue_cnt;

   int checks = 0;
   int errors = 0;
   int sent;
   int recv;

   logic [7:0] cols [8] = '{8'hA8, 8'h68, 8'hA4, 8'h64, 8'hA2, 8'h62, 8'hA1, 8'h61};

   always #5 clk = ~clk;

   edc_corrector #(.AW(32), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
      .i_addr(in_addr), .i_data(in_data), .i_ecc(in_ecc),
      .o_valid(out_valid), .i_ready(in_ready), .o_addr(out_addr), .o_data(out_data),
      .o_ce(out_ce), .o_ue(out_ue), .o_syndrome(out_syn), .i_cnt_clr(cnt_clr),
      .o_ce_cnt(ce_cnt), .o_ue_cnt(ue_cnt), .o_err_addr(err_addr), .o_err_vld(err_vld)
   );

   edc_corrector #(.AW(32), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(d2_ready),
      .i_addr(in_addr), .i_data(in_data), .i_ecc(in_ecc),
      .o_valid(d2_valid), .i_ready(in_ready), .o_addr(d2_addr), .o_data(d2_data),
      .o_ce(d2_ce), .o_ue(d2_ue), .o_syndrome(d2_syn), .i_cnt_clr(cnt_clr),
      .o_ce_cnt(d2_ce_cnt), .o_ue_cnt(d2_ue_cnt), .o_err_addr(d2_err_addr), .o_err_vld(d2_err_vld)
   );

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one word, then waits until it sits in stage 2.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] ecc);
      in_valid = 1'b1;
      in_addr  = addr;
      in_data  = data;
      in_ecc   = ecc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic ce, input logic ue, input logic [7:0] syn);
      checkValue({tag, "_valid"}, out_valid, 1);
      checkValue({tag, "_addr"}, out_addr, addr);
      checkValue({tag, "_data"}, out_data, data);
      checkValue({tag, "_ce"}, out_ce, ce);
      checkValue({tag, "_ue"}, out_ue, ue);
      checkValue({tag, "_syn"}, out_syn, syn);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1; cnt_clr = 1'b0;
      in_addr = '0; in_data = '0; in_ecc = '0;
      repeat (2) @(posedge clk);
      #1;
      checkValue("rst_valid", out_valid, 0);
      checkValue("rst_ready", out_ready, 1);
      checkValue("rst_data", out_data, 0);
      checkValue("rst_addr", out_addr, 0);
      checkValue("rst_flags", {out_ce, out_ue}, 0);
      checkValue("rst_syn", out_syn, 0);
      checkValue("rst_cnts", {ce_cnt, ue_cnt}, 0);
      checkValue("rst_err", {err_vld, err_addr}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(32'h100, 32'h0000_0000, 8'h00);
      checkOutput("clean", 32'h100, 32'h0, 0, 0, 8'h00);
      @(posedge clk); #1;
      checkValue("clean_ce_cnt", ce_cnt, 0);
      checkValue("clean_err_vld", err_vld, 0);

      applyStimulus(32'h104, 32'h0000_0001, 8'h00);
      checkOutput("bit0", 32'h104, 32'h0, 1, 0, 8'hA8);
      @(posedge clk); #1;
      checkValue("bit0_ce_cnt", ce_cnt, 1);
      checkValue("bit0_err_vld", err_vld, 1);
      checkValue("bit0_err_addr", err_addr, 32'h104);

      applyStimulus(32'h108, 32'h0000_0000, 8'h01);
      checkOutput("chk0", 32'h108, 32'h0, 1, 0, 8'h01);
      @(posedge clk); #1;
      checkValue("chk0_ce_cnt", ce_cnt, 2);
      checkValue("chk0_err_addr", err_addr, 32'h104);

      applyStimulus(32'h10C, 32'h0000_0003, 8'h00);
      checkOutput("dbl", 32'h10C, 32'h3, 0, 1, 8'hC0);
      @(posedge clk); #1;
      checkValue("dbl_ue_cnt", ue_cnt, 1);

      applyStimulus(32'h110, 32'h8000_0000, 8'h00);
      checkOutput("bit31", 32'h110, 32'h0, 1, 0, 8'h15);
      @(posedge clk); #1;
      checkValue("bit31_ce_cnt", ce_cnt, 3);

      applyStimulus(32'h114, 32'h0000_0000, 8'h07);
      checkOutput("odd_nocol", 32'h114, 32'h0, 0, 1, 8'h07);
      @(posedge clk); #1;
      checkValue("odd_nocol_ue_cnt", ue_cnt, 2);

      applyStimulus(32'h118, 32'h0001_0000, 8'h8A);
      checkOutput("good16", 32'h118, 32'h0001_0000, 0, 0, 8'h00);
      @(posedge clk); #1;

      applyStimulus(32'h11C, 32'h0000_8000, 8'h00);
      checkOutput("bit15", 32'h11C, 32'h0, 1, 0, 8'h51);
      @(posedge clk); #1;

      applyStimulus(32'h120, 32'hFFFF_FFFF, 8'h80);
      checkOutput("chk7", 32'h120, 32'hFFFF_FFFF, 1, 0, 8'h80);
      @(posedge clk); #1;
      checkValue("chk7_ce_cnt", ce_cnt, 5);
      checkValue("sat_d2_early", d2_ce_cnt, 3);

      // Continuous stream with a three-cycle consumer stall once stage 2 is full.
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         in_valid = (sent < 8);
         in_addr  = 32'h200 + 32'(sent);
         in_data  = 32'h1 << (sent % 8);
         in_ecc   = cols[sent % 8];
         in_ready = !(cyc >= 4 && cyc < 7);
         #1;
         checkValue("stream_ready", out_ready, !(cyc >= 4 && cyc < 7));
         if (out_valid) begin
            checkValue("stream_addr", out_addr, 32'h200 + 32'(recv));
            checkValue("stream_data", out_data, 32'h1 << recv);
            checkValue("stream_flags", {out_ce, out_ue}, 0);
            if (in_ready) recv++;
         end
         if (in_valid && out_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_ready = 1'b1;
      checkValue("stream_count", recv, 8);

      applyStimulus(32'h300, 32'h0000_0001, 8'h00);
      checkValue("clr_word_ce", out_ce, 1);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      checkValue("clr_ce_cnt", ce_cnt, 0);
      checkValue("clr_ue_cnt", ue_cnt, 0);
      checkValue("clr_err_vld", err_vld, 0);

      for (int k = 0; k < 5; k++) begin
         applyStimulus(32'h400 + 32'(k), 32'h0000_0001, 8'h00);
         @(posedge clk); #1;
      end
      checkValue("sat_ce_cnt16", ce_cnt, 5);
      checkValue("sat_ce_cnt2", d2_ce_cnt, 3);
      checkValue("sat_err_addr", err_addr, 32'h400);
      checkValue("sat_err_vld", err_vld, 1);

      in_valid = 1'b1;
      in_addr  = 32'h500;
      in_data  = 32'h0000_0001;
      in_ecc   = 8'h00;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      checkValue("midrst_valid0", out_valid, 0);
      @(posedge clk); #1;
      checkValue("midrst_valid1", out_valid, 0);
      checkValue("midrst_ce_cnt", ce_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
